// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle MIPS controller: state enum, opcodes,
// datapath mux encodings and the per-state control decode.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // fetch marks FETCH, where irwrite/pcwrite follow mem_ready outside the register
  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch    = 1'b1;
        c.memread  = 1'b1;
        c.alusrcb  = SRCB_FOUR;
        c.aluop    = ALUOP_ADD;
        c.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_BOFF;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_ADDI_WB: c.regwrite = 1'b1;
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_B;
        c.aluop       = ALUOP_SUB;
        c.pcwritecond = 1'b1;
        c.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction through its states,
// stalls on mem_ready in memory states, counts retirements, sticks in HALT.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int              OP_W    = 6,
  parameter int              CNT_W   = 32,
  parameter logic [OP_W-1:0] HALT_OP = 6'h3F,
  parameter bit              EN_BNE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             branch_ne,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [OP_W-1:0] RTYPE = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] JMP   = OP_W'(OP_J);
  localparam logic [OP_W-1:0] BEQ   = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] BNE   = OP_W'(OP_BNE);
  localparam logic [OP_W-1:0] ADDI  = OP_W'(OP_ADDI);
  localparam logic [OP_W-1:0] LW    = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] SW    = OP_W'(OP_SW);

  state_t           state_reg, state_next;
  ctrl_t            ctrl_reg;
  logic             branch_ne_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] count_reg;
  logic             retire;

  // The zero flag is consumed by the datapath's branch logic, not the FSM.
  logic unused_zero;
  assign unused_zero = zero;

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == LW || opcode == SW)                 state_next = S_MEMADR;
        else if (opcode == RTYPE)                         state_next = S_EXEC;
        else if (opcode == ADDI)                          state_next = S_ADDI_EX;
        else if (opcode == BEQ || (EN_BNE && opcode == BNE)) state_next = S_BRANCH;
        else if (opcode == JMP)                           state_next = S_JUMP;
        else if (opcode == HALT_OP)                       state_next = S_HALT;
        else                                              state_next = S_FETCH;
      end
      S_MEMADR:  state_next = (opcode == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXEC:    state_next = S_ALUWB;
      S_ADDI_EX: state_next = S_ADDI_WB;
      S_MEMWB, S_ALUWB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_BOOT;
    endcase
  end

  // Controls are registered from the next state so they stay glitch-free Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_BOOT;
      ctrl_reg      <= '0;
      branch_ne_reg <= 1'b0;
      halted_reg    <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ctrl_reg      <= ctrl_decode(state_next);
      branch_ne_reg <= (state_next == S_BRANCH) && (opcode == BNE);
      halted_reg    <= halted_reg | (state_next == S_HALT);
      if (retire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign irwrite     = ctrl_reg.fetch & mem_ready;
  assign pcwrite     = ctrl_reg.pcwrite | (ctrl_reg.fetch & mem_ready);
  assign pcwritecond = ctrl_reg.pcwritecond;
  assign iord        = ctrl_reg.iord;
  assign memread     = ctrl_reg.memread;
  assign memwrite    = ctrl_reg.memwrite;
  assign memtoreg    = ctrl_reg.memtoreg;
  assign regdst      = ctrl_reg.regdst;
  assign regwrite    = ctrl_reg.regwrite;
  assign alusrca     = ctrl_reg.alusrca;
  assign alusrcb     = ctrl_reg.alusrcb;
  assign aluop       = ctrl_reg.aluop;
  assign pcsource    = ctrl_reg.pcsource;
  assign branch_ne   = branch_ne_reg;
  assign illegal_op  = (state_reg == S_DECODE) && (state_next == S_FETCH);
  assign halted      = halted_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: two controllers (default, and CNT_W=4 with bne disabled)
// checked every cycle against an instruction-level step-list model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       branch_ne, illegal_op, halted;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic waits;
    logic is_wr;
  } step_t;

  localparam int K_BOOT = 0, K_FETCH = 1, K_DEC = 2, K_STEP = 3, K_HALT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       zero;
  logic [5:0] opc [2];
  logic       rdy [2];

  logic       pcwrite_o [2], pcwritecond_o [2], iord_o [2], memread_o [2];
  logic       memwrite_o [2], irwrite_o [2], memtoreg_o [2], regdst_o [2];
  logic       regwrite_o [2], alusrca_o [2], branch_ne_o [2], illegal_o [2];
  logic       halted_o [2];
  logic [1:0] alusrcb_o [2], aluop_o [2], pcsource_o [2];
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    kind [2];
  int    pos [2];
  int    len [2];
  longint mcnt [2];
  step_t steps [2][3];
  int    halt_cycles;
  bit    wr_rst_done;

  always #5 clk = ~clk;

  multicycle_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opc[0]), .zero(zero), .mem_ready(rdy[0]),
    .pcwrite(pcwrite_o[0]), .pcwritecond(pcwritecond_o[0]), .iord(iord_o[0]),
    .memread(memread_o[0]), .memwrite(memwrite_o[0]), .irwrite(irwrite_o[0]),
    .memtoreg(memtoreg_o[0]), .regdst(regdst_o[0]), .regwrite(regwrite_o[0]),
    .alusrca(alusrca_o[0]), .alusrcb(alusrcb_o[0]), .aluop(aluop_o[0]),
    .pcsource(pcsource_o[0]), .branch_ne(branch_ne_o[0]), .illegal_op(illegal_o[0]),
    .halted(halted_o[0]), .instr_count(cnt_a)
  );

  multicycle_ctrl #(.CNT_W(4), .EN_BNE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opc[1]), .zero(zero), .mem_ready(rdy[1]),
    .pcwrite(pcwrite_o[1]), .pcwritecond(pcwritecond_o[1]), .iord(iord_o[1]),
    .memread(memread_o[1]), .memwrite(memwrite_o[1]), .irwrite(irwrite_o[1]),
    .memtoreg(memtoreg_o[1]), .regdst(regdst_o[1]), .regwrite(regwrite_o[1]),
    .alusrca(alusrca_o[1]), .alusrcb(alusrcb_o[1]), .aluop(aluop_o[1]),
    .pcsource(pcsource_o[1]), .branch_ne(branch_ne_o[1]), .illegal_op(illegal_o[1]),
    .halted(halted_o[1]), .instr_count(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t got_obs(input int d);
    return {pcwrite_o[d], pcwritecond_o[d], iord_o[d], memread_o[d], memwrite_o[d],
            irwrite_o[d], memtoreg_o[d], regdst_o[d], regwrite_o[d], alusrca_o[d],
            alusrcb_o[d], aluop_o[d], pcsource_o[d], branch_ne_o[d], illegal_o[d],
            halted_o[d]};
  endfunction

  function automatic logic [31:0] got_cnt(input int d);
    return (d == 0) ? cnt_a : {28'd0, cnt_b};
  endfunction

  function automatic logic [31:0] exp_cnt(input int d);
    return (d == 0) ? mcnt[d][31:0] : {28'd0, mcnt[d][3:0]};
  endfunction

  function automatic bit legal(input int d, input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02, 6'h3F} ||
           (op == 6'h05 && d == 0);
  endfunction

  task automatic push(input int d, input obs_t o, input logic w, input logic wr);
    steps[d][len[d]] = '{o: o, waits: w, is_wr: wr};
    len[d]++;
  endtask

  // Expand an opcode into the list of post-decode steps it must walk through.
  task automatic build(input int d, input logic [5:0] op);
    obs_t o;
    len[d] = 0;
    pos[d] = 0;
    if (!legal(d, op)) begin
      kind[d] = K_FETCH;
      return;
    end
    if (op == 6'h3F) begin
      kind[d] = K_HALT;
      return;
    end
    case (op)
      6'h23, 6'h2B: begin
        o = '0; o.alusrca = 1; o.alusrcb = 2'b10; push(d, o, 0, 0);
        if (op == 6'h23) begin
          o = '0; o.memread = 1; o.iord = 1; push(d, o, 1, 0);
          o = '0; o.regwrite = 1; o.memtoreg = 1; push(d, o, 0, 0);
        end else begin
          o = '0; o.memwrite = 1; o.iord = 1; push(d, o, 1, 1);
        end
      end
      6'h00: begin
        o = '0; o.alusrca = 1; o.aluop = 2'b10; push(d, o, 0, 0);
        o = '0; o.regwrite = 1; o.regdst = 1; push(d, o, 0, 0);
      end
      6'h08: begin
        o = '0; o.alusrca = 1; o.alusrcb = 2'b10; push(d, o, 0, 0);
        o = '0; o.regwrite = 1; push(d, o, 0, 0);
      end
      6'h04, 6'h05: begin
        o = '0; o.alusrca = 1; o.aluop = 2'b01; o.pcwritecond = 1; o.pcsource = 2'b01;
        o.branch_ne = (op == 6'h05); push(d, o, 0, 0);
      end
      default: begin
        o = '0; o.pcwrite = 1; o.pcsource = 2'b10; push(d, o, 0, 0);
      end
    endcase
    kind[d] = K_STEP;
  endtask

  task automatic advance(input int d);
    case (kind[d])
      K_BOOT:  kind[d] = K_FETCH;
      K_FETCH: if (rdy[d]) kind[d] = K_DEC;
      K_DEC:   build(d, opc[d]);
      K_STEP: begin
        if (!(steps[d][pos[d]].waits && !rdy[d])) begin
          pos[d]++;
          if (pos[d] == len[d]) begin
            kind[d] = K_FETCH;
            mcnt[d]++;
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic obs_t expect_obs(input int d);
    obs_t o;
    o = '0;
    case (kind[d])
      K_FETCH: begin
        o.memread = 1; o.alusrcb = 2'b01;
        o.irwrite = rdy[d]; o.pcwrite = rdy[d];
      end
      K_DEC: begin
        o.alusrcb = 2'b11;
        o.illegal_op = !legal(d, opc[d]);
      end
      K_STEP:  o = steps[d][pos[d]].o;
      K_HALT:  o.halted = 1;
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal_ops [7];
    logic [5:0] bad_ops [4];
    int r;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};
    bad_ops   = '{6'h01, 6'h10, 6'h3E, 6'h2A};
    r = $urandom_range(0, 299);
    if (r == 0) return 6'h3F;
    if (r < 20) return bad_ops[$urandom_range(0, 3)];
    return legal_ops[$urandom_range(0, 6)];
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("ctl%0d_k%0d", d, kind[d]), 32'(got_obs(d)), 32'(expect_obs(d)));
      check_eq($sformatf("cnt%0d", d), got_cnt(d), exp_cnt(d));
    end
  endtask

  // Assert reset between clock edges and confirm outputs clear with no edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_ctl%0d", d), 32'(got_obs(d)), 32'd0);
      check_eq($sformatf("rst_cnt%0d", d), got_cnt(d), 32'd0);
      kind[d] = K_BOOT;
      mcnt[d] = 0;
    end
    halt_cycles = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    zero  = 1'b0;
    halt_cycles = 0;
    wr_rst_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      opc[d] = 6'h00; rdy[d] = 1'b1; kind[d] = K_BOOT; mcnt[d] = 0; pos[d] = 0; len[d] = 0;
    end
    #12;
    compare_all();
    repeat (6000) begin
      @(posedge clk);
      if (rst_n) begin
        advance(0);
        advance(1);
      end
      #1;
      rst_n = 1'b1;
      zero  = 1'($urandom_range(0, 1));
      for (int d = 0; d < 2; d++) begin
        rdy[d] = ($urandom_range(0, 3) != 0);
        if (kind[d] == K_BOOT || kind[d] == K_FETCH || kind[d] == K_HALT) opc[d] = pick_op();
      end
      @(negedge clk);
      compare_all();
      if (kind[0] == K_HALT || kind[1] == K_HALT) halt_cycles++;
      else halt_cycles = 0;
      if (kind[0] == K_STEP && steps[0][pos[0]].is_wr && !wr_rst_done) begin
        wr_rst_done = 1'b1;
        check_eq("memwr_pre", {31'd0, memwrite_o[0]}, 32'd1);
        async_reset();
      end else if (halt_cycles >= 20 || $urandom_range(0, 799) == 0) begin
        async_reset();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
